// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: read-side consumer for the asynchronous FIFO.
// It pops DSIZE-bit words from the FIFO read port and packs RATIO of them
// little-endian into one wide word. A flush request closes a partial word
// so that a packet tail is not left stranded in the accumulator.
// Optional feature macro: FIFO_RD_PACK_STATS_EN adds the word_count port
// and its counter.
//
// Output stream handshake: a word transfers on a rising rclk edge where
// m_valid and m_ready are both 1. Once m_valid is raised, m_valid, m_data,
// m_cnt and m_last hold stable until that transfer happens. m_ready may
// change freely and is never used to form m_valid.
module fifo_rd_pack #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
`ifdef FIFO_RD_PACK_STATS_EN
  ,
  parameter int CNTW  = 16
`endif
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  input  logic                     rempty,
  input  logic [DSIZE-1:0]         rdata,
  output logic                     rinc,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DSIZE*RATIO-1:0]   m_data,
  output logic [$clog2(RATIO):0]   m_cnt,
  output logic                     m_last
`ifdef FIFO_RD_PACK_STATS_EN
  ,
  output logic [CNTW-1:0]          word_count
`endif
);

  localparam int IW = $clog2(RATIO) + 1;
  localparam logic [IW-1:0] FULL = IW'(RATIO);

  logic [DSIZE-1:0]       acc [RATIO];
  logic [IW-1:0]          idx;
  logic                   flush_pend;
  logic                   out_free;
  logic                   xfer;
  logic                   pop;
  logic [DSIZE*RATIO-1:0] pack;

  // Transfer and pop decisions. The pop may overlap a full-word transfer,
  // which is what sustains one FIFO word per cycle.
  always_comb begin
    out_free = !m_valid || m_ready;
    xfer     = out_free && ((idx == FULL) || (flush_pend && (idx != '0)));
    pop      = !rempty && !flush_pend && ((idx < FULL) || xfer);
    rinc     = pop;
  end

  // Wide word as it would be loaded now: lanes at or above idx read as zero.
  always_comb begin
    pack = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (IW'(i) < idx) begin
        pack[i*DSIZE +: DSIZE] = acc[i];
      end
    end
  end

  // Accumulator: fill index and lane storage. A pop during a transfer
  // lands in lane 0 of the next word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      idx <= '0;
      for (int i = 0; i < RATIO; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (xfer) begin
        idx <= pop ? IW'(1) : '0;
      end else if (pop) begin
        idx <= idx + IW'(1);
      end
      for (int i = 0; i < RATIO; i++) begin
        if (pop && ((xfer && (i == 0)) || (!xfer && (idx == IW'(i))))) begin
          acc[i] <= rdata;
        end
      end
    end
  end

  // Flush request: a new pulse arms it; it clears once the partial word
  // transfers, or one cycle later when there was nothing to emit.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      flush_pend <= 1'b0;
    end else if (flush && !flush_pend) begin
      flush_pend <= 1'b1;
    end else if (xfer || (idx == '0)) begin
      flush_pend <= 1'b0;
    end
  end

  // Output register: loads on transfer, empties on acceptance.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_cnt   <= '0;
      m_last  <= 1'b0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= pack;
      m_cnt   <= idx;
      m_last  <= flush_pend;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_PACK_STATS_EN
  // Accepted output words, wrapping modulo 2^CNTW.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      word_count <= '0;
    end else if (m_valid && m_ready) begin
      word_count <= word_count + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Bench for fifo_rd_pack (DSIZE=8, RATIO=4). A small FIFO model feeds the
// read port; expected output words go into exp_q and a monitor pops and
// compares them on every accepted word. Define FIFO_RD_PACK_STATS_EN to
// build the counter variant (CNTW=4).
module tb_fifo_rd_pack;
  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int W     = DSIZE*RATIO + 3 + 1;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;

  logic              rempty;
  logic [DSIZE-1:0]  rdata;
  logic              rinc;
  logic              flush = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [31:0]       m_data;
  logic [2:0]        m_cnt;
  logic              m_last;
`ifdef FIFO_RD_PACK_STATS_EN
  logic [3:0]        word_count;
`endif

  fifo_rd_pack #(
    .DSIZE(DSIZE),
    .RATIO(RATIO)
`ifdef FIFO_RD_PACK_STATS_EN
    ,
    .CNTW(4)
`endif
  ) dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .rempty(rempty),
    .rdata(rdata),
    .rinc(rinc),
    .flush(flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_cnt(m_cnt),
    .m_last(m_last)
`ifdef FIFO_RD_PACK_STATS_EN
    ,
    .word_count(word_count)
`endif
  );

  // ---------------- FIFO model ----------------
  logic [7:0]  mem [0:511];
  logic [15:0] wr_ptr = '0;
  logic [15:0] rd_ptr;
  int          pop_cnt;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr[8:0]];

  // FIFO read pointer shares rrst_n; reset discards anything queued.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr  <= wr_ptr;
      pop_cnt <= 0;
    end else if (rinc) begin
      rd_ptr  <= rd_ptr + 16'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] c, input logic l);
    exp_q.push_back({d, c, l});
  endtask

  // Monitor: compare on acceptance, check hold stability while stalled.
  always @(negedge rclk) begin
    if (rrst_n && m_valid) begin
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {m_data, m_cnt, m_last}, '0);
        end else begin
          check("out_word", {m_data, m_cnt, m_last}, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        check("stall_hold", {m_data, m_cnt, m_last}, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    mem[wr_ptr[8:0]] = b;
    wr_ptr = wr_ptr + 16'd1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      @(negedge rclk);
      n++;
    end
    check(name, 64'(exp_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    logic [31:0] w;

    // Reset state
    #3;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_cnt", m_cnt, 0);
    check("rst_m_last", m_last, 0);
    check("rst_rinc_empty", rinc, 0);
    step();
    rrst_n = 1'b1;
    step();

    // Streaming: 8 bytes, m_ready high, 8 consecutive pops
    m_ready = 1'b1;
    expect_word(32'h44332211, 3'd4, 1'b0);
    expect_word(32'h88776655, 3'd4, 1'b0);
    for (int i = 1; i <= 8; i++) load(8'(i * 8'h11));
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      check("stream_rinc", rinc, 1);
    end
    @(negedge rclk);
    check("stream_rinc_done", rinc, 0);
    wait_drain("stream_drain");

    // Backpressure: 12 bytes, m_ready low for 10 cycles
    step();
    m_ready = 1'b0;
    p0 = pop_cnt;
    expect_word(32'h04030201, 3'd4, 1'b0);
    expect_word(32'h08070605, 3'd4, 1'b0);
    expect_word(32'h0C0B0A09, 3'd4, 1'b0);
    for (int i = 1; i <= 12; i++) load(8'(i));
    repeat (10) step();
    @(negedge rclk);
    check("bp_pops", 64'(pop_cnt - p0), 8);
    check("bp_rinc_low", rinc, 0);
    check("bp_valid", m_valid, 1);
    step();
    m_ready = 1'b1;
    wait_drain("bp_drain");

    // Partial flush: 3 bytes then flush; a byte queued behind it waits
    step();
    expect_word(32'h00A3A2A1, 3'd3, 1'b1);
    expect_word(32'h000000B0, 3'd1, 1'b1);
    load(8'hA1); load(8'hA2); load(8'hA3);
    repeat (5) step();
    check("pf_no_early_out", m_valid, 0);
    pulse_flush();
    load(8'hB0);
    @(negedge rclk);
    check("pf_pop_blocked", rinc, 0);
    @(negedge rclk);
    check("pf_pop_resume", rinc, 1);
    step();
    step();
    pulse_flush();
    wait_drain("pf_drain");

    // Flush on an empty accumulator: nothing emitted, pops resume
    step();
    pulse_flush();
    load(8'h31);
    @(negedge rclk);
    check("ef_pop_blocked", rinc, 0);
    @(negedge rclk);
    check("ef_pop_resume", rinc, 1);
    expect_word(32'h34333231, 3'd4, 1'b0);
    step();
    load(8'h32); load(8'h33); load(8'h34);
    wait_drain("ef_drain");

    // Flush with a full accumulator behind a stalled output word
    step();
    m_ready = 1'b0;
    expect_word(32'hC4C3C2C1, 3'd4, 1'b0);
    expect_word(32'hC8C7C6C5, 3'd4, 1'b1);
    for (int i = 1; i <= 8; i++) load(8'(8'hC0 + i));
    repeat (10) step();
    pulse_flush();
    repeat (3) step();
    m_ready = 1'b1;
    wait_drain("ff_drain");

    // Reset mid-word: held output and partial accumulator are discarded
    step();
    m_ready = 1'b0;
    expect_word(32'hE4E3E2E1, 3'd4, 1'b0);
    for (int i = 1; i <= 6; i++) load(8'(8'hE0 + i));
    repeat (8) step();
    check("mr_valid_before", m_valid, 1);
    #3;
    rrst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mr_m_valid", m_valid, 0);
    check("mr_m_data", m_data, 0);
    check("mr_m_cnt", m_cnt, 0);
    check("mr_m_last", m_last, 0);
`ifdef FIFO_RD_PACK_STATS_EN
    check("mr_word_count", word_count, 0);
`endif
    load(8'h5A);
    #1;
    check("mr_rinc_in_reset", rinc, 1);
    step();
    step();
    rrst_n = 1'b1;
    m_ready = 1'b1;
    expect_word(32'hD4D3D2D1, 3'd4, 1'b0);
    load(8'hD1); load(8'hD2); load(8'hD3); load(8'hD4);
    wait_drain("mr_drain");

    // 16 more words (17 since reset) for the stats wrap
    for (int k = 0; k < 16; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      expect_word(w, 3'd4, 1'b0);
      for (int j = 0; j < 4; j++) load(8'(4*k + j));
    end
    wait_drain("long_drain");
`ifdef FIFO_RD_PACK_STATS_EN
    step();
    check("stats_wrap", word_count, 1);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
